sar_scan_ctrl: RTL and testbench

SAR_SCAN_CTRL -- requirements
Module: sar_scan_ctrl

---
 rtl/sar_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sar_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_ctrl.sv
// Round-robin scan controller for a 4-channel SAR ADC front end.
// Sequences sample/hold, SAR start, conversion wait with timeout, and a ready/valid result port.
module sar_scan_ctrl #(
  parameter int unsigned SAMPLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rest,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic [1:0] ch_sel,
  output logic       sh,
  output logic       sar_ena,
  input  logic       sar_done,
  input  logic [5:0] sar_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_data,
  output logic [1:0] res_ch,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StStart,
    StConvert,
    StOutput
  } state_e;

  localparam logic [5:0] SampleLast = 6'(SAMPLE_CYC - 1);
  localparam logic [5:0] TimeoutCnt = 6'(TIMEOUT_CYC);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [1:0] ch_sel_q, ch_sel_d;
  logic [3:0] ack_q, ack_d;
  logic       sh_q, sh_d;
  logic       sar_ena_q, sar_ena_d;
  logic       res_valid_q, res_valid_d;
  logic [5:0] res_data_q, res_data_d;
  logic [1:0] res_ch_q, res_ch_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic [1:0] grant;
  logic [1:0] idx;
  logic       found;

  // Search starts one past the last serviced channel and wraps mod 4.
  always_comb begin
    grant = last_q + 2'd1;
    idx   = last_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = last_q + 2'(i + 1);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    ch_sel_d    = ch_sel_q;
    ack_d       = 4'b0000;
    sh_d        = 1'b0;
    sar_ena_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          ch_sel_d = grant;
          cnt_d    = 6'd0;
          sh_d     = 1'b1;
          state_d  = StSample;
        end
      end
      StSample: begin
        if (cnt_q == SampleLast) begin
          cnt_d     = 6'd0;
          sar_ena_d = 1'b1;
          state_d   = StStart;
        end else begin
          cnt_d = cnt_q + 6'd1;
          sh_d  = 1'b1;
        end
      end
      StStart: begin
        // First CONVERT cycle is the first cycle after the start pulse.
        cnt_d   = 6'd1;
        state_d = StConvert;
      end
      StConvert: begin
        if (sar_done) begin
          res_data_d  = sar_data;
          res_ch_d    = ch_sel_q;
          res_valid_d = 1'b1;
          cnt_d       = 6'd0;
          state_d     = StOutput;
        end else if (cnt_q + 6'd1 == TimeoutCnt) begin
          err_d   = 1'b1;
          last_d  = ch_sel_q;
          cnt_d   = 6'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StOutput: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ack_d       = 4'b0001 << res_ch_q;
          last_d      = res_ch_q;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      last_q      <= 2'd3;
      ch_sel_q    <= 2'd0;
      ack_q       <= 4'b0000;
      sh_q        <= 1'b0;
      sar_ena_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 6'd0;
      res_ch_q    <= 2'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ch_sel_q    <= ch_sel_d;
      ack_q       <= ack_d;
      sh_q        <= sh_d;
      sar_ena_q   <= sar_ena_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign ack       = ack_q;
  assign ch_sel    = ch_sel_q;
  assign sh        = sh_q;
  assign sar_ena   = sar_ena_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed self-checking bench for sar_scan_ctrl: single request, round-robin contention,
// backpressure, timeout, reset mid-conversion and spurious done strobes.
module tb_sar_scan_ctrl;

  logic       clk = 1'b0;
  logic       rest;
  logic [3:0] req;
  logic [3:0] ack;
  logic [1:0] ch_sel;
  logic       sh;
  logic       sar_ena;
  logic       sar_done;
  logic [5:0] sar_data;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_data;
  logic [1:0] res_ch;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sar_scan_ctrl #(
    .SAMPLE_CYC (4),
    .TIMEOUT_CYC(15)
  ) u_dut (
    .clk      (clk),
    .rest     (rest),
    .req      (req),
    .ack      (ack),
    .ch_sel   (ch_sel),
    .sh       (sh),
    .sar_ena  (sar_ena),
    .sar_done (sar_done),
    .sar_data (sar_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_ch   (res_ch),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rest      = 1'b0;
    req       = 4'b0000;
    sar_done  = 1'b0;
    sar_data  = 6'd0;
    res_ready = 1'b0;
    step();
    step();
    rest = 1'b1;
  endtask

  task automatic wait_ena();
    for (int i = 0; i < 40 && !sar_ena; i++) step();
    check("ena_seen", 32'(sar_ena), 32'd1);
  endtask

  // Pulse sar_done d cycles after the current (start-pulse) cycle.
  task automatic finish_conv(input int d, input logic [5:0] data);
    repeat (d) step();
    sar_done = 1'b1;
    sar_data = data;
    step();
    sar_done = 1'b0;
    sar_data = 6'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         sh_cnt;
    int         ena_cnt;
    logic       ack_seen;
    logic [1:0] e;

    // Reset values
    do_reset();
    rest = 1'b0;
    #1;
    check("rst_outputs", {13'd0, ack, ch_sel, sh, sar_ena, res_valid, res_data, res_ch, busy, err},
          32'd0);
    rest = 1'b1;

    // Single request on channel 0, done 7 cycles after start
    do_reset();
    req       = 4'b0001;
    res_ready = 1'b1;
    step();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ch_sel", 32'(ch_sel), 32'd0);
    sh_cnt = 0;
    for (int i = 0; i < 20 && !sar_ena; i++) begin
      if (sh) sh_cnt++;
      step();
    end
    check("t1_ena", 32'(sar_ena), 32'd1);
    check("t1_sh_cycles", 32'(sh_cnt), 32'd4);
    check("t1_sh_low_at_start", 32'(sh), 32'd0);
    ena_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (sar_ena) ena_cnt++;
    end
    check("t1_single_ena", 32'(ena_cnt), 32'd0);
    sar_done = 1'b1;
    sar_data = 6'h2A;
    step();
    sar_done = 1'b0;
    sar_data = 6'd0;
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_data", 32'(res_data), 32'h2A);
    check("t1_res_ch", 32'(res_ch), 32'd0);
    step();
    check("t1_ack", 32'(ack), 32'b0001);
    check("t1_valid_drop", 32'(res_valid), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    req = 4'b0000;
    step();
    check("t1_ack_pulse", 32'(ack), 32'd0);
    check("t1_stay_idle", 32'(busy), 32'd0);

    // Contention: all four held, expect 0,1,2,3,0 with one idle cycle between
    do_reset();
    req       = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = 2'(k);
      wait_ena();
      check("rr_ch_sel", 32'(ch_sel), 32'(e));
      finish_conv(3, {4'b0000, e});
      check("rr_valid", 32'(res_valid), 32'd1);
      check("rr_res_ch", 32'(res_ch), 32'(e));
      check("rr_res_data", 32'(res_data), 32'(e));
      step();
      check("rr_ack", 32'(ack), 32'd1 << e);
      check("rr_idle_gap", 32'(busy), 32'd0);
      step();
      check("rr_rearb", {30'd0, busy, sh}, 32'b11);
    end

    // Backpressure: result held for 10 cycles
    do_reset();
    req = 4'b0010;
    wait_ena();
    finish_conv(2, 6'h15);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {19'd0, res_valid, res_ch, res_data, ack}, {19'd0, 1'b1, 2'd1, 6'h15, 4'b0});
      step();
    end
    check("bp_still_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    step();
    check("bp_ack", 32'(ack), 32'b0010);
    check("bp_valid_drop", 32'(res_valid), 32'd0);
    req = 4'b0000;

    // Timeout: no done, err at start+15, no ack, next channel granted
    do_reset();
    req       = 4'b0011;
    res_ready = 1'b1;
    wait_ena();
    check("to_ch0", 32'(ch_sel), 32'd0);
    ack_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (ack != 4'b0000) ack_seen = 1'b1;
    end
    check("to_err_early", 32'(err), 32'd0);
    check("to_busy_pre", 32'(busy), 32'd1);
    step();
    check("to_err", 32'(err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    check("to_no_ack", 32'(ack_seen | (ack != 4'b0000)), 32'd0);
    step();
    check("to_next_ch", 32'(ch_sel), 32'd1);
    check("to_next_sh", 32'(sh), 32'd1);
    wait_ena();
    finish_conv(1, 6'h11);
    check("to_recover_data", 32'(res_data), 32'h11);
    step();
    check("to_recover_ack", 32'(ack), 32'b0010);
    check("to_err_sticky", 32'(err), 32'd1);
    req = 4'b0000;
    do_reset();
    check("to_err_cleared", 32'(err), 32'd0);

    // Reset two cycles after the start pulse
    req       = 4'b0100;
    res_ready = 1'b1;
    wait_ena();
    step();
    step();
    check("mr_pre_ch_sel", 32'(ch_sel), 32'd2);
    rest = 1'b0;
    #1;
    check("mr_async_outputs",
          {13'd0, ack, ch_sel, sh, sar_ena, res_valid, res_data, res_ch, busy, err}, 32'd0);
    req = 4'b0000;
    step();
    rest     = 1'b1;
    sar_done = 1'b1;
    sar_data = 6'h3C;
    step();
    sar_done = 1'b0;
    sar_data = 6'd0;
    check("mr_late_done_valid", 32'(res_valid), 32'd0);
    check("mr_late_done_busy", 32'(busy), 32'd0);
    step();
    check("mr_no_ack", {27'd0, ack, res_valid}, 32'd0);

    // Spurious done in IDLE and SAMPLE; request dropped after grant still completes
    do_reset();
    sar_done = 1'b1;
    sar_data = 6'h01;
    step();
    sar_done = 1'b0;
    check("sp_idle_busy", 32'(busy), 32'd0);
    check("sp_idle_valid", 32'(res_valid), 32'd0);
    req = 4'b1000;
    step();
    check("sp_grant_ch3", 32'(ch_sel), 32'd3);
    req      = 4'b0000;
    sar_done = 1'b1;
    step();
    sar_done = 1'b0;
    check("sp_sample_valid", 32'(res_valid), 32'd0);
    check("sp_sample_sh", 32'(sh), 32'd1);
    wait_ena();
    check("sp_ch_stable", 32'(ch_sel), 32'd3);
    finish_conv(2, 6'h3F);
    check("sp_valid", 32'(res_valid), 32'd1);
    check("sp_data", 32'(res_data), 32'h3F);
    check("sp_res_ch", 32'(res_ch), 32'd3);
    res_ready = 1'b1;
    step();
    check("sp_ack", 32'(ack), 32'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
